shared_port_arbiter: RTL

Round-robin arbiter and sequencer that shares one multi-cycle device port (for example a shared data memory or I/O bus) between NUM_REQ processor cores or pipeline requesters. Each requester holds a request and sees a per-requester stall until its access completes. The arbiter issues one access at a time to the device and honours the device's wait signal. It sits between the cores' memory-stage stall logic and the shared device.

---
 rtl/shared_port_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/shared_port_arbiter.sv
// shared_port_arbiter
// Round-robin arbiter that shares one multi-cycle device port between
// NUM_REQ requesters. Only one access is in flight at a time. The device's
// wait signal stretches the access, and the device port is idle between
// accesses.
//
// State | Meaning
// IDLE  | no access in flight; pick the next winner round-robin from ptr_q
// ISSUE | dev_en_o strobe for the latched command
// WAIT  | hold the command until dev_wait_i drops, then capture read data
// RESP  | done_o pulse to the owner; the owner's stall is released
//
// Ports
//   clk_i, reset_i      clock, synchronous active-high reset
//   req_i/req_we_i      per-requester level request and write enable
//   req_addr_i/wdata_i  flattened per-requester command, slice i*W +: W
//   stalled_o           per-requester stall (combinational)
//   done_o, grant_o     one-hot completion pulse / current owner
//   rdata_o             last captured device read data
//   dev_*               device-side command and handshake
module shared_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [NUM_REQ-1:0]    req_we_i,
    input  logic [NUM_REQ*AW-1:0] req_addr_i,
    input  logic [NUM_REQ*DW-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]    stalled_o,
    output logic [NUM_REQ-1:0]    done_o,
    output logic [NUM_REQ-1:0]    grant_o,
    output logic [DW-1:0]         rdata_o,
    output logic                  dev_en_o,
    output logic                  dev_we_o,
    output logic [AW-1:0]         dev_addr_o,
    output logic [DW-1:0]         dev_wdata_o,
    input  logic [DW-1:0]         dev_rdata_i,
    input  logic                  dev_wait_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          win_found;
    logic [IW-1:0] win_idx;
    logic [NUM_REQ-1:0] owner_oh;
    logic          active;

    // Scan from ptr_q upward with wrap; the first set request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req_i[(int'(ptr_q) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                win_idx   = IW'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    owner_d = win_idx;
                    we_d    = req_we_i[win_idx];
                    addr_d  = req_addr_i[int'(win_idx)*AW +: AW];
                    wdata_d = req_wdata_i[int'(win_idx)*DW +: DW];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (!dev_wait_i) begin
                    rdata_d = dev_rdata_i;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                // Advancing past the owner keeps a re-requesting owner from
                // winning again while others wait.
                ptr_d   = (owner_q == IW'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign owner_oh    = NUM_REQ'(1) << owner_q;
    assign active      = (state_q != S_IDLE);
    assign grant_o     = active ? owner_oh : '0;
    assign done_o      = (state_q == S_RESP) ? owner_oh : '0;
    assign stalled_o   = req_i & ~done_o;
    assign dev_en_o    = (state_q == S_ISSUE);
    assign dev_we_o    = active & we_q;
    assign dev_addr_o  = active ? addr_q : '0;
    assign dev_wdata_o = active ? wdata_q : '0;
    assign rdata_o     = rdata_q;

endmodule
